// File: rtl/muldiv4_share_ctrl_if.sv
// Requester-side request/response channels of the shared 4-bit multiply/divide sequencer.
// Bit/nibble/byte i of every field belongs to requester i.
interface muldiv4_share_ctrl_if;
    localparam int unsigned N_REQ = 2;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned RES_W = 8;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*NIB_W-1:0] req_a;
    logic [N_REQ*NIB_W-1:0] req_b;
    logic [N_REQ-1:0]       req_op;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [N_REQ*RES_W-1:0] rsp_data;
    logic [N_REQ-1:0]       rsp_dbz;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_dbz
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_dbz
    );
endinterface

// File: rtl/muldiv4_share_ctrl.sv
// Round-robin arbiter/sequencer sharing one 4-bit multiply/divide unit between two
// requesters; divide-by-zero is optionally answered locally without starting the unit.
module muldiv4_share_ctrl #(
    parameter int unsigned LATENCY  = 2,
    parameter bit          DBZ_TRAP = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    muldiv4_share_ctrl_if.slave   bus,
    output logic                  busy,
    output logic [3:0]            mdu_a,
    output logic [3:0]            mdu_b,
    output logic                  mdu_op,
    output logic                  mdu_start,
    input  logic [7:0]            mdu_result
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned RES_W = 8;
    localparam int unsigned RSP_W = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state, state_nxt;
    logic             last_grant, last_grant_nxt;
    logic             id, id_nxt;
    logic             dbz, dbz_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [NIB_W-1:0] mdu_a_nxt, mdu_b_nxt;
    logic             mdu_op_nxt, mdu_start_nxt;
    logic [1:0]       rsp_valid_nxt, rsp_dbz_nxt;
    logic [RSP_W-1:0] rsp_data_nxt;
    logic             busy_nxt;

    logic             grant;
    logic [NIB_W-1:0] sel_a, sel_b;
    logic             sel_op, sel_dbz;

    function automatic logic [1:0] onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [RSP_W-1:0] place_byte(input logic sel, input logic [RES_W-1:0] val);
        return sel ? {val, 8'h00} : {8'h00, val};
    endfunction

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            id            <= 1'b0;
            dbz           <= 1'b0;
            cnt           <= '0;
            mdu_a         <= '0;
            mdu_b         <= '0;
            mdu_op        <= 1'b0;
            mdu_start     <= 1'b0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_dbz   <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            last_grant    <= last_grant_nxt;
            id            <= id_nxt;
            dbz           <= dbz_nxt;
            cnt           <= cnt_nxt;
            mdu_a         <= mdu_a_nxt;
            mdu_b         <= mdu_b_nxt;
            mdu_op        <= mdu_op_nxt;
            mdu_start     <= mdu_start_nxt;
            bus.rsp_valid <= rsp_valid_nxt;
            bus.rsp_data  <= rsp_data_nxt;
            bus.rsp_dbz   <= rsp_dbz_nxt;
            busy          <= busy_nxt;
        end
    end

    // Arbitration, next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        id_nxt         = id;
        dbz_nxt        = dbz;
        cnt_nxt        = cnt;
        mdu_a_nxt      = mdu_a;
        mdu_b_nxt      = mdu_b;
        mdu_op_nxt     = mdu_op;
        mdu_start_nxt  = 1'b0;
        rsp_valid_nxt  = bus.rsp_valid;
        rsp_data_nxt   = bus.rsp_data;
        rsp_dbz_nxt    = bus.rsp_dbz;
        bus.req_ready  = 2'b00;

        // Contention goes to whoever did not win last time
        grant   = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];
        sel_a   = grant ? bus.req_a[7:4] : bus.req_a[3:0];
        sel_b   = grant ? bus.req_b[7:4] : bus.req_b[3:0];
        sel_op  = grant ? bus.req_op[1]  : bus.req_op[0];
        sel_dbz = sel_op && (sel_b == '0);

        case (state)
            IDLE: begin
                if (bus.req_valid[grant]) begin
                    bus.req_ready  = onehot(grant);
                    mdu_a_nxt      = sel_a;
                    mdu_b_nxt      = sel_b;
                    mdu_op_nxt     = sel_op;
                    id_nxt         = grant;
                    last_grant_nxt = grant;
                    dbz_nxt        = sel_dbz;
                    if (sel_dbz && DBZ_TRAP) begin
                        rsp_valid_nxt = onehot(grant);
                        rsp_dbz_nxt   = onehot(grant);
                        rsp_data_nxt  = place_byte(grant, {sel_a, 4'hF});
                        state_nxt     = RESP;
                    end else begin
                        mdu_start_nxt = 1'b1;
                        state_nxt     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_nxt   = CNT_W'(LATENCY - 1);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    rsp_valid_nxt = onehot(id);
                    rsp_dbz_nxt   = dbz ? onehot(id) : 2'b00;
                    rsp_data_nxt  = place_byte(id, mdu_result);
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready[id]) begin
                    rsp_valid_nxt = 2'b00;
                    rsp_dbz_nxt   = 2'b00;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end
endmodule

// File: tb/tb_muldiv4_share_ctrl.sv
// Directed bench for muldiv4_share_ctrl with a behavioural multiply/divide unit whose
// result is only valid exactly LAT cycles after the start cycle.
module tb_muldiv4_share_ctrl;
    localparam int unsigned LAT = 2;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [3:0] mdu_a, mdu_b;
    logic       mdu_op, mdu_start;
    logic [7:0] mdu_result;

    int checks   = 0;
    int failures = 0;

    muldiv4_share_ctrl_if bus();

    muldiv4_share_ctrl #(.LATENCY(LAT), .DBZ_TRAP(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .busy       (busy),
        .mdu_a      (mdu_a),
        .mdu_b      (mdu_b),
        .mdu_op     (mdu_op),
        .mdu_start  (mdu_start),
        .mdu_result (mdu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural unit: garbage except in the exact result cycle
    int unsigned age;
    logic [7:0]  pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age  <= 0;
            pend <= 8'h00;
        end else if (mdu_start) begin
            age  <= 1;
            if (mdu_op == 1'b0)  pend <= 8'(mdu_a * mdu_b);
            else if (mdu_b == 0) pend <= {mdu_a, 4'hF};
            else                 pend <= {4'(mdu_a % mdu_b), 4'(mdu_a / mdu_b)};
        end else if (age != 0 && age < 1000) begin
            age <= age + 1;
        end
    end
    assign mdu_result = (age == LAT) ? pend : 8'hA5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rid;
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_data;
        logic       exp_dbz;
    } vec_t;

    vec_t vecs[9];

    task automatic run_txn(input vec_t v);
        logic [1:0] oh;
        int n, starts, start_n;
        bit got;
        oh = v.rid ? 2'b10 : 2'b01;
        bus.req_valid = oh;
        bus.req_a     = v.rid ? {v.a, 4'h0} : {4'h0, v.a};
        bus.req_b     = v.rid ? {v.b, 4'h0} : {4'h0, v.b};
        bus.req_op    = v.rid ? {v.op, 1'b0} : {1'b0, v.op};
        bus.rsp_ready = 2'b11;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready != 2'b00) begin got = 1; break; end
            @(negedge clk);
        end
        check("accept", 32'(got), 32'd1);
        check("req_ready", 32'(bus.req_ready), 32'(oh));
        check("busy_idle", 32'(busy), 32'd0);
        got = 0; n = 0; starts = 0; start_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            bus.req_valid = 2'b00;
            if (mdu_start) begin starts++; start_n = n; end
            if (n == 2 && bus.rsp_valid == 2'b00) begin
                check("wait_mdu_a", 32'(mdu_a), 32'(v.a));
                check("wait_mdu_b", 32'(mdu_b), 32'(v.b));
                check("wait_mdu_op", 32'(mdu_op), 32'(v.op));
            end
            if (bus.rsp_valid != 2'b00) begin got = 1; break; end
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("latency", 32'(n), v.exp_dbz ? 32'd1 : 32'(LAT + 2));
        check("start_count", 32'(starts), v.exp_dbz ? 32'd0 : 32'd1);
        check("start_cycle", 32'(start_n), v.exp_dbz ? 32'd0 : 32'd1);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
        check("rsp_data", 32'(bus.rsp_data), v.rid ? 32'({v.exp_data, 8'h00}) : 32'(v.exp_data));
        check("rsp_dbz", 32'(bus.rsp_dbz), v.exp_dbz ? 32'(oh) : 32'd0);
        @(negedge clk);
        check("after_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("after_rsp_dbz", 32'(bus.rsp_dbz), 32'd0);
        check("after_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [1:0] oh;
        bit got;
        int seen;

        vecs[0] = '{1'b0, 1'b0, 4'd3,  4'd5,  8'h0F, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'd13, 4'd4,  8'h13, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 4'd9,  4'd0,  8'h9F, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 4'd7,  4'd9,  8'h3F, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 4'd15, 4'd1,  8'h0F, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 4'd2,  4'd7,  8'h20, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 4'd5,  4'd0,  8'h5F, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 4'd0,  4'd12, 8'h00, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 4'd15, 4'd15, 8'hE1, 1'b0};

        rst_n = 1'b0;
        bus.req_valid = 2'b00; bus.req_a = 8'h00; bus.req_b = 8'h00;
        bus.req_op = 2'b00; bus.rsp_ready = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_dbz", 32'(bus.rsp_dbz), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mdu", 32'({mdu_a, mdu_b, mdu_op, mdu_start}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters held valid: grants alternate starting with requester 0
        bus.req_valid = 2'b11;
        bus.req_a     = {4'd9, 4'd15};
        bus.req_b     = {4'd2, 4'd15};
        bus.req_op    = 2'b10;
        bus.rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            oh = (k % 2 == 1) ? 2'b10 : 2'b01;
            got = 0;
            for (int i = 0; i < 20; i++) begin
                #1;
                if (bus.req_ready != 2'b00) begin got = 1; break; end
                @(negedge clk);
            end
            check("arb_accept", 32'(got), 32'd1);
            check("arb_grant", 32'(bus.req_ready), 32'(oh));
            got = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.rsp_valid != 2'b00) begin got = 1; break; end
            end
            check("arb_rsp_valid", 32'(bus.rsp_valid), 32'(oh));
            check("arb_rsp_data", 32'(bus.rsp_data), (k % 2 == 1) ? 32'h1400 : 32'h00E1);
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("arb_idle_busy", 32'(busy), 32'd0);

        // Back-pressure on requester 0 while requester 1 waits
        bus.req_valid = 2'b01; bus.req_a = 8'h03; bus.req_b = 8'h05; bus.req_op = 2'b00;
        bus.rsp_ready = 2'b10;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready != 2'b00) begin got = 1; break; end
            @(negedge clk);
        end
        check("bp_accept", 32'(got), 32'd1);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.req_valid = 2'b00;
            if (bus.rsp_valid != 2'b00) begin got = 1; break; end
        end
        check("bp_rsp_seen", 32'(got), 32'd1);
        bus.req_valid = 2'b10; bus.req_a = 8'h10; bus.req_b = 8'h10;
        for (int j = 0; j < 5; j++) begin
            #1;
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_hold_data", 32'(bus.rsp_data), 32'h000F);
            check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
            check("bp_hold_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        #1;
        check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_release_ready", 32'(bus.req_ready), 32'd2);
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("bp_drop_not_served", 32'(busy), 32'd0);

        // Reset asserted while waiting on the unit
        bus.req_valid = 2'b10; bus.req_a = 8'h70; bus.req_b = 8'h90; bus.req_op = 2'b00;
        bus.rsp_ready = 2'b11;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready != 2'b00) begin got = 1; break; end
            @(negedge clk);
        end
        check("rw_accept", 32'(got), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        check("rw_start", 32'(mdu_start), 32'd1);
        @(negedge clk);
        check("rw_busy_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_rst_busy", 32'(busy), 32'd0);
        check("rw_rst_mdu", 32'({mdu_a, mdu_b, mdu_op, mdu_start}), 32'd0);
        check("rw_rst_rsp", 32'({bus.rsp_valid, bus.rsp_dbz, bus.rsp_data}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00 || busy) seen++;
        end
        check("rw_no_response", 32'(seen), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv4_share_ctrl.md
Name: muldiv4_share_ctrl

Overview:
Round-robin arbiter and sequencer that shares one 4-bit multiply/divide unit between two requesters. Each request is accepted through a valid/ready handshake. The block drives the unit's operand/op/start inputs, waits a fixed unit latency, captures the 8-bit result and returns it on the originating requester's response channel. Divide-by-zero is trapped locally, and the unit is not started for it.

Parameters:
LATENCY, 2, cycles from the mdu_start pulse to a valid mdu_result; legal range 1..15.
DBZ_TRAP, 1, 1 = divide-by-zero is answered locally without starting the unit; 0 = issued to the unit like any other op, with rsp_dbz still flagged.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-requester request valid; bit i = requester i
req_ready  output  2  per-requester accept; at most one bit high
req_a  input  8  operand A, nibble i = requester i
req_b  input  8  operand B, nibble i = requester i
req_op  input  2  bit i: 0 = multiply, 1 = divide
rsp_valid  output  2  per-requester response valid
rsp_ready  input  2  per-requester response accept
rsp_data  output  16  byte i = result for requester i
rsp_dbz  output  2  divide-by-zero flag, qualified by rsp_valid
busy  output  1  high in every state except IDLE
mdu_a  output  4  operand A to the unit
mdu_b  output  4  operand B to the unit
mdu_op  output  1  op select to the unit
mdu_start  output  1  one-cycle start pulse
mdu_result  input  8  unit result: multiply = product; divide = {remainder, quotient}

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_grant=1 (requester 0 wins first), mdu_a/mdu_b/mdu_op=0, mdu_start=0, rsp_valid=0, rsp_data=0, rsp_dbz=0, busy=0. A reset in any state aborts the operation and drops any pending response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant g = the only valid requester; if both are valid, g = !last_grant.
  - req_ready[g] is combinational (state==IDLE && req_valid[g]). No other bit is high.
  - On handshake: capture operands into mdu_a/mdu_b/mdu_op, and register id=g and last_grant=g.
  - If req_op[g]=1, b=0 and DBZ_TRAP=1: result={a,4'hF}, dbz=1, go to RESP; mdu_start is never asserted.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): mdu_start=1; cnt loaded with LATENCY-1; go to WAIT.
- WAIT: mdu_a/mdu_b/mdu_op are held stable. If cnt==0, capture mdu_result into the result register and go to RESP; otherwise cnt decrements.
  - Result is sampled exactly LATENCY cycles after the mdu_start cycle.
- RESP:
  - rsp_valid[id]=1 and rsp_data byte id = result. Other bytes and bits are 0.
  - rsp_dbz[id] = dbz (the div-by-zero condition, also when DBZ_TRAP=0).
  - Held stable until rsp_ready[id]=1. On that edge: rsp_valid and rsp_dbz clear, go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
- Arbitration is decided at IDLE only. A requester that drops req_valid before handshake is not served. There is no preemption.
- Minimum per-transaction time with rsp_ready tied high: LATENCY+3 cycles (IDLE, ISSUE, WAIT×LATENCY, RESP).
- All outputs except req_ready are registered.

Test Plan:
- Reset, then req0 mul a=3,b=5, rsp_ready=1 → mdu_start pulse 1 cycle after accept; rsp_valid[0] after LATENCY+2 cycles; rsp_data[7:0]=0x0F; rsp_dbz=0.
- req1 div a=13,b=4 → rsp_data[15:8]=0x13 (rem 1, quo 3); rsp_valid[0] stays 0.
- Both valid from reset (mul 15×15 and div 9/2) → req0 served first (0xE1), then req1 (0x14). Repeat both held valid → grants alternate 0,1,0,1.
- req0 div 9/0 with DBZ_TRAP=1 → mdu_start never high; rsp_data[7:0]=0x9F; rsp_dbz[0]=1.
- Back-pressure: rsp_ready[0]=0 for 5 cycles → rsp_valid/data held, req_ready=00, busy=1; release → IDLE next cycle.
- Assert rst_n=0 during WAIT → all outputs go to reset values immediately; no response after release; next request is served normally.
